// File: rtl/rgb_pkg.sv
// Shared colour constants, FSM encoding and helpers for the colour-fade datapath.
package rgb_pkg;

    // Palette entries, {R,G,B}
    localparam logic [23:0] RGB_RED    = 24'h7F_00_00;
    localparam logic [23:0] RGB_ORANGE = 24'h7F_52_00;
    localparam logic [23:0] RGB_YELLOW = 24'h7F_7F_00;
    localparam logic [23:0] RGB_GREEN  = 24'h00_7F_00;
    localparam logic [23:0] RGB_BLUE   = 24'h00_00_7F;
    localparam logic [23:0] RGB_INDIGO = 24'h25_00_41;
    localparam logic [23:0] RGB_VIOLET = 24'h77_41_77;

    // 1 ms per step at 100 MHz
    localparam int STEP_DIV_DEF = 100000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FADE = 1'b1
    } fade_state_t;

    // Move one 8-bit channel one count toward its target; equal holds.
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt) begin
            return cur + 8'd1;
        end else if (cur > tgt) begin
            return cur - 8'd1;
        end else begin
            return cur;
        end
    endfunction

endpackage

// File: rtl/fade_tick.sv
// Fade-step prescaler: counts 0..STEP_DIV-1 while enabled, ticks on the wrap cycle.
module fade_tick
    import rgb_pkg::*;
#(
    parameter int STEP_DIV = STEP_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W   = $clog2(STEP_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance and wrap while enabled.
    always_comb begin
        tick  = en && (cnt_q == CNT_MAX);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/color_fade.sv
// Ramps three 8-bit PWM duties toward a target colour, one count per step tick.
module color_fade
    import rgb_pkg::*;
#(
    parameter int          STEP_DIV = STEP_DIV_DEF,
    parameter logic [23:0] INIT_RGB = RGB_RED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] tgt_rgb,
    input  logic        tgt_valid,
    output logic        tgt_ready,
    output logic [7:0]  duty_r,
    output logic [7:0]  duty_g,
    output logic [7:0]  duty_b,
    output logic        busy,
    output logic        done
);

    fade_state_t state_q, state_d;
    logic [23:0] duty_q, duty_d;
    logic [23:0] tgt_q, tgt_d;
    logic        done_q, done_d;
    logic        presc_clr;
    logic        tick;
    logic        xfer;

    fade_tick #(
        .STEP_DIV(STEP_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (presc_clr),
        .en  (state_q == ST_FADE),
        .tick(tick)
    );

    // Ready follows reset directly so the first edge after reset can transfer.
    assign tgt_ready = !rst;
    assign xfer      = tgt_valid && tgt_ready;

    // Next state, duty stepping and target capture; a retarget beats completion.
    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        tgt_d     = tgt_q;
        done_d    = 1'b0;
        presc_clr = 1'b0;

        if (tick) begin
            duty_d = {step_toward(duty_q[23:16], tgt_q[23:16]),
                      step_toward(duty_q[15:8],  tgt_q[15:8]),
                      step_toward(duty_q[7:0],   tgt_q[7:0])};
        end

        if (xfer) begin
            tgt_d = tgt_rgb;
        end

        if (state_q == ST_IDLE) begin
            if (xfer) begin
                if (tgt_rgb != duty_q) begin
                    state_d   = ST_FADE;
                    presc_clr = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end
        end else begin
            if (!xfer && tick && (duty_d == tgt_q)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    // State, duty, target and done registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            duty_q  <= INIT_RGB;
            tgt_q   <= INIT_RGB;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            done_q  <= done_d;
        end
    end

    assign duty_r = duty_q[23:16];
    assign duty_g = duty_q[15:8];
    assign duty_b = duty_q[7:0];
    assign busy   = (state_q == ST_FADE);
    assign done   = done_q;

endmodule

// File: tb/tb_color_fade.sv
// Self-checking bench for color_fade with a cycle-level behavioural colour model.
module tb_color_fade;

    localparam int          STEP = 4;
    localparam logic [23:0] INIT = 24'h7F_00_00;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] tgt_rgb;
    logic        tgt_valid;
    logic        tgt_ready;
    logic [7:0]  duty_r, duty_g, duty_b;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    // Behavioural model: channel values as integers, fade flag, cycles into current step
    int md[3];
    int mt[3];
    bit m_fade;
    int m_phase;
    bit m_done;
    bit m_rst;

    color_fade #(
        .STEP_DIV(STEP),
        .INIT_RGB(INIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tgt_rgb  (tgt_rgb),
        .tgt_valid(tgt_valid),
        .tgt_ready(tgt_ready),
        .duty_r   (duty_r),
        .duty_g   (duty_g),
        .duty_b   (duty_b),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] model_vec();
        return {8'(md[0]), 8'(md[1]), 8'(md[2]), m_fade, m_done, !m_rst};
    endfunction

    function automatic logic [26:0] dut_vec();
        return {duty_r, duty_g, duty_b, busy, done, tgt_ready};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle.
    task automatic cyc(input logic r, input logic v, input logic [23:0] d);
        bit tick_now;
        bit all_eq;
        rst = r; tgt_valid = v; tgt_rgb = d; m_rst = r;
        @(posedge clk);
        if (r) begin
            md[0] = INIT[23:16]; md[1] = INIT[15:8]; md[2] = INIT[7:0];
            mt[0] = INIT[23:16]; mt[1] = INIT[15:8]; mt[2] = INIT[7:0];
            m_fade = 0; m_phase = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (!m_fade) begin
                if (v) begin
                    all_eq = (d[23:16] == md[0]) && (d[15:8] == md[1]) && (d[7:0] == md[2]);
                    mt[0] = d[23:16]; mt[1] = d[15:8]; mt[2] = d[7:0];
                    if (all_eq) m_done = 1;
                    else begin m_fade = 1; m_phase = 0; end
                end
            end else begin
                m_phase = m_phase + 1;
                tick_now = (m_phase == STEP);
                if (tick_now) begin
                    m_phase = 0;
                    for (int i = 0; i < 3; i++) begin
                        if (md[i] < mt[i]) md[i] = md[i] + 1;
                        else if (md[i] > mt[i]) md[i] = md[i] - 1;
                    end
                end
                if (v) begin
                    mt[0] = d[23:16]; mt[1] = d[15:8]; mt[2] = d[7:0];
                end else if (tick_now && md[0] == mt[0] && md[1] == mt[1] && md[2] == mt[2]) begin
                    m_fade = 0; m_done = 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int dones = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 24'h0);
            checks++;
            if (dut_vec() !== model_vec() || tgt_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: got %h want %h", dut_vec(), model_vec());
            end
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 24'h0);
            if (done) dones++;
        end
        checks++;
        if ({duty_r, duty_g, duty_b, busy} !== {24'h7F0000, 1'b0} || dones != 0) begin
            errors++;
            $display("FAIL reset_idle: got %h busy %b dones %0d want 7f0000 busy 0 dones 0",
                     {duty_r, duty_g, duty_b}, busy, dones);
        end
    endtask

    task automatic test_red_to_green();
        int dones = 0;
        int n = 0;
        cyc(1'b0, 1'b1, 24'h007F00);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL r2g_start: busy %b done %b want 1 0", busy, done);
        end
        while (!done && n < 700) begin
            cyc(1'b0, 1'b0, 24'h0);
            n++;
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL r2g_track: cycle %0d got %h want %h", n, dut_vec(), model_vec());
            end
            if (done) dones++;
        end
        checks++;
        if (n != 127 * STEP) begin
            errors++;
            $display("FAIL r2g_duration: got %0d cycles want %0d", n, 127 * STEP);
        end
        cyc(1'b0, 1'b0, 24'h0);
        if (done) dones++;
        checks++;
        if ({duty_r, duty_g, duty_b, busy, done} !== {24'h007F00, 2'b00} || dones != 1) begin
            errors++;
            $display("FAIL r2g_final: got %h busy %b dones %0d want 007f00 0 1",
                     {duty_r, duty_g, duty_b}, busy, dones);
        end
    endtask

    task automatic test_same_colour();
        cyc(1'b1, 1'b0, 24'h0);
        cyc(1'b0, 1'b0, 24'h0);
        cyc(1'b0, 1'b1, 24'h7F0000);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL same_first: busy %b done %b want 0 1", busy, done);
        end
        cyc(1'b0, 1'b0, 24'h0);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL same_second: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_retarget();
        int n = 0;
        int dones = 0;
        int last_tick = -1;
        int gaps_bad = 0;
        logic [23:0] prev;
        cyc(1'b1, 1'b0, 24'h0);
        cyc(1'b0, 1'b1, 24'h007F00);
        while (duty_r !== 8'h40 && n < 700) begin
            cyc(1'b0, 1'b0, 24'h0);
            n++;
        end
        checks++;
        if (duty_r !== 8'h40) begin
            errors++;
            $display("FAIL retgt_reach40: got %h want 40", duty_r);
        end
        n = 0;
        prev = {duty_r, duty_g, duty_b};
        cyc(1'b0, 1'b1, 24'h00007F);
        while (!done && n < 1500) begin
            prev = {duty_r, duty_g, duty_b};
            cyc(1'b0, 1'b0, 24'h0);
            n++;
            if ({duty_r, duty_g, duty_b} != prev) begin
                if (last_tick >= 0 && n - last_tick != STEP) gaps_bad++;
                last_tick = n;
            end
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL retgt_track: cycle %0d got %h want %h", n, dut_vec(), model_vec());
            end
            if (done) dones++;
        end
        cyc(1'b0, 1'b0, 24'h0);
        if (done) dones++;
        checks++;
        if ({duty_r, duty_g, duty_b} !== 24'h00007F || dones != 1 || gaps_bad != 0) begin
            errors++;
            $display("FAIL retgt_final: got %h dones %0d bad_gaps %0d want 00007f 1 0",
                     {duty_r, duty_g, duty_b}, dones, gaps_bad);
        end
    endtask

    task automatic test_mid_reset();
        int dones = 0;
        cyc(1'b1, 1'b0, 24'h0);
        cyc(1'b0, 1'b1, 24'h007F00);
        for (int i = 0; i < 30; i++) cyc(1'b0, 1'b0, 24'h0);
        cyc(1'b1, 1'b0, 24'h0);
        checks++;
        if ({duty_r, duty_g, duty_b, busy, done} !== {24'h7F0000, 2'b00}) begin
            errors++;
            $display("FAIL midrst_abort: got %h busy %b done %b want 7f0000 0 0",
                     {duty_r, duty_g, duty_b}, busy, done);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 24'h0);
            if (done) dones++;
        end
        cyc(1'b0, 1'b1, 24'h00007F);
        checks++;
        if (dones != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_after: dones %0d busy %b want 0 1", dones, busy);
        end
    endtask

    task automatic test_final_edge_retarget();
        int n = 0;
        cyc(1'b1, 1'b0, 24'h0);
        cyc(1'b0, 1'b1, 24'h7E0000);
        for (int i = 0; i < STEP - 1; i++) cyc(1'b0, 1'b0, 24'h0);
        cyc(1'b0, 1'b1, 24'h7E0001);
        checks++;
        if ({duty_r, duty_g, duty_b, busy, done} !== {24'h7E0000, 2'b10}) begin
            errors++;
            $display("FAIL fedge_prio: got %h busy %b done %b want 7e0000 1 0",
                     {duty_r, duty_g, duty_b}, busy, done);
        end
        while (!done && n < 100) begin
            cyc(1'b0, 1'b0, 24'h0);
            n++;
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL fedge_track: cycle %0d got %h want %h", n, dut_vec(), model_vec());
            end
        end
        checks++;
        if ({duty_r, duty_g, duty_b} !== 24'h7E0001 || done !== 1'b1 || n != STEP) begin
            errors++;
            $display("FAIL fedge_final: got %h done %b cycles %0d want 7e0001 1 %0d",
                     {duty_r, duty_g, duty_b}, done, n, STEP);
        end
    endtask

    task automatic test_random();
        logic [23:0] d;
        bit v;
        cyc(1'b1, 1'b0, 24'h0);
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(0, 24) == 0);
            d = 24'($urandom);
            if ($urandom_range(0, 3) == 0) d = {duty_r, duty_g, duty_b};
            else if ($urandom_range(0, 1) == 0)
                d = {duty_r ^ 8'($urandom_range(0, 3)), duty_g ^ 8'($urandom_range(0, 3)),
                     duty_b ^ 8'($urandom_range(0, 3))};
            cyc(($urandom_range(0, 300) == 0), v, d);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random: cycle %0d got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; tgt_valid = 1'b0; tgt_rgb = 24'h0; m_rst = 1'b1;
        md[0] = 0; md[1] = 0; md[2] = 0; mt[0] = 0; mt[1] = 0; mt[2] = 0;
        m_fade = 0; m_phase = 0; m_done = 0;
        test_reset();
        test_red_to_green();
        test_same_colour();
        test_retarget();
        test_mid_reset();
        test_final_edge_retarget();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
